// File: rtl/systolic_mm_engine_if.sv
// Job control, operand beat stream and result handoff for systolic_mm_engine.
interface systolic_mm_engine_if #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 16
);
  logic                        start;
  logic [LEN_WIDTH-1:0]        len;
  logic                        busy;
  logic [DATA_WIDTH*M-1:0]     x_data;
  logic [DATA_WIDTH*K-1:0]     w_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [ACC_WIDTH*M*K-1:0]    y_out;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output start, len, x_data, w_data, in_valid, out_ready,
    input  busy, in_ready, y_out, out_valid
  );

  modport slave (
    input  start, len, x_data, w_data, in_valid, out_ready,
    output busy, in_ready, y_out, out_valid
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary MxK systolic matmul: result valid len+M+K edges after start; bubbles add one cycle each.
// in_ready only in LOAD; result held in DONE until out_ready, the array itself never stalls.
module systolic_mm_engine #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LEN_WIDTH  = 16,
  parameter bit SIGNED     = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  systolic_mm_engine_if.slave bus
);
  localparam int CNT_W  = $clog2(M + K + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [LEN_WIDTH-1:0]     len_q, beat_cnt;
  logic [CNT_W-1:0]         drain_cnt;
  logic                     accept, clr_acc, capture;
  logic [DATA_WIDTH-1:0]    x_q   [M][K];
  logic [DATA_WIDTH-1:0]    w_q   [M][K];
  logic [ACC_WIDTH-1:0]     acc_q [M][K];
  logic [ACC_WIDTH*M*K-1:0] y_q;

  assign accept        = (state == LOAD) && bus.in_valid;
  assign bus.in_ready  = (state == LOAD);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.y_out     = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_acc   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          clr_acc   = 1'b1;
          state_nxt = (bus.len != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        if (accept && (beat_cnt == len_q - LEN_WIDTH'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Last DRAIN edge: the final beat has just landed in PE(M-1,K-1).
        if (drain_cnt == CNT_W'(M + K - 1)) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (clr_acc) begin
        len_q    <= bus.len;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < K; j++)
          y_q[(i*K+j)*ACC_WIDTH +: ACC_WIDTH] <= acc_q[i][j];
    end
  end

  // Idle edges push zeros so the wavefront keeps moving without a stall path.
  for (genvar m = 0; m < M; m++) begin : g_xskew
    logic [DATA_WIDTH-1:0] sr [m+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= m; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept ? bus.x_data[m*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= m; s++) sr[s] <= sr[s-1];
      end
    end
    assign x_q[m][0] = sr[m];
  end

  for (genvar k = 0; k < K; k++) begin : g_wskew
    logic [DATA_WIDTH-1:0] sr [k+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= k; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept ? bus.w_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= k; s++) sr[s] <= sr[s-1];
      end
    end
    assign w_q[0][k] = sr[k];
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_pe
      logic [PROD_W-1:0]    x_ext, w_ext, prod;
      logic [ACC_WIDTH-1:0] prod_ext, acc;

      assign x_ext = {{DATA_WIDTH{SIGNED & x_q[i][j][DATA_WIDTH-1]}}, x_q[i][j]};
      assign w_ext = {{DATA_WIDTH{SIGNED & w_q[i][j][DATA_WIDTH-1]}}, w_q[i][j]};
      assign prod  = x_ext * w_ext;

      if (ACC_WIDTH > PROD_W) begin : g_ext
        assign prod_ext = {{(ACC_WIDTH-PROD_W){SIGNED & prod[PROD_W-1]}}, prod};
      end else begin : g_noext
        assign prod_ext = prod;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (clr_acc) acc <= '0;
        else              acc <= acc + prod_ext;
      end
      assign acc_q[i][j] = acc;

      if (j < K - 1) begin : g_xfwd
        logic [DATA_WIDTH-1:0] xr;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) xr <= '0;
          else        xr <= x_q[i][j];
        end
        assign x_q[i][j+1] = xr;
      end

      if (i < M - 1) begin : g_wfwd
        logic [DATA_WIDTH-1:0] wr;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) wr <= '0;
          else        wr <= w_q[i][j];
        end
        assign w_q[i+1][j] = wr;
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench: a signed 40-bit engine and an unsigned 32-bit engine run in lockstep on shared stimulus.
module tb_systolic_mm_engine;
  localparam int M   = 4;
  localparam int K   = 4;
  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int AWU = 32;
  localparam int LW  = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, in_valid, out_ready;
  logic [LW-1:0] len;
  logic [DW*M-1:0] x_data;
  logic [DW*K-1:0] w_data;
  int n_cmp = 0;
  int n_err = 0;

  systolic_mm_engine_if #(.M(M), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW),  .LEN_WIDTH(LW)) bus_s ();
  systolic_mm_engine_if #(.M(M), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AWU), .LEN_WIDTH(LW)) bus_u ();

  assign bus_s.start = start;     assign bus_u.start = start;
  assign bus_s.len = len;         assign bus_u.len = len;
  assign bus_s.x_data = x_data;   assign bus_u.x_data = x_data;
  assign bus_s.w_data = w_data;   assign bus_u.w_data = w_data;
  assign bus_s.in_valid = in_valid;   assign bus_u.in_valid = in_valid;
  assign bus_s.out_ready = out_ready; assign bus_u.out_ready = out_ready;

  systolic_mm_engine #(.M(M), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW), .SIGNED(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  systolic_mm_engine #(.M(M), .K(K), .DATA_WIDTH(DW), .ACC_WIDTH(AWU), .LEN_WIDTH(LW), .SIGNED(1'b0))
    dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] ys(input int idx);
    return bus_s.y_out[idx*AW +: AW];
  endfunction

  function automatic logic [AWU-1:0] yu(input int idx);
    return bus_u.y_out[idx*AWU +: AWU];
  endfunction

  task automatic check_all(input string tag, input logic [AW-1:0] exp_s);
    for (int i = 0; i < M*K; i++) check(tag, ys(i), exp_s);
  endtask

  task automatic check_all_u(input string tag, input logic [AWU-1:0] exp_u);
    for (int i = 0; i < M*K; i++) check(tag, yu(i), exp_u);
  endtask

  // Starts a job, streams beats per vpat (bit e-1 = in_valid before edge e), returns once out_valid is seen.
  task automatic run_job(input string tag, input int n, input logic [63:0] xd, input logic [63:0] wd,
                         input logic [31:0] vpat, input bit start_in_load, input int exp_lat, input int exp_rdy);
    int lat = -1;
    int rdy = 0;
    start = 1'b1; len = LW'(n); x_data = xd; w_data = wd; in_valid = 1'b0;
    step();
    for (int e = 1; e <= 200; e++) begin
      start = start_in_load;
      if (start_in_load) len = LW'(7);
      in_valid = (e - 1 < 32) ? vpat[e-1] : 1'b1;
      if (bus_s.in_ready) rdy++;
      step();
      if (bus_s.out_valid) begin
        lat = e;
        break;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_ready_cycles"}, rdy, exp_rdy);
  endtask

  // Holds DONE for 'hold' cycles with start pulsed, then releases; start stays high on the release edge.
  task automatic release_job(input string tag, input int hold, input logic [AW-1:0] exp_last);
    for (int c = 0; c < hold; c++) begin
      start = 1'b1; out_ready = 1'b0;
      step();
      check({tag, "_hold_valid"}, bus_s.out_valid, 1);
      check({tag, "_hold_y"}, ys(M*K-1), exp_last);
    end
    start = 1'b1; out_ready = 1'b1;
    step();
    check({tag, "_release_valid"}, bus_s.out_valid, 0);
    check({tag, "_release_busy"}, bus_s.busy, 0);
    start = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    start = 1'b0; len = '0; x_data = '0; w_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", |bus_s.y_out, 0);
    check("reset_out_valid", bus_s.out_valid, 0);
    check("reset_in_ready", bus_s.in_ready, 0);
    check("reset_busy", bus_s.busy, 0);
    rst_n = 1'b1;
    step();

    // len=3, ones times twos, no bubbles
    run_job("ones", 3, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 32'hFFFF_FFFF, 1'b0, 11, 3);
    check_all("ones_y", 40'd6);
    check_all_u("ones_yu", 32'd6);
    release_job("ones", 5, 40'd6);

    // same job with bubbles 1,0,1,0,1 and start held high through LOAD/DRAIN
    run_job("bubble", 3, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 32'hFFFF_FFF5, 1'b1, 13, 5);
    check_all("bubble_y", 40'd6);
    release_job("bubble", 0, 40'd6);

    // back-to-back job with distinct lanes: Y[m][k] = 2(m+1)(k+1)
    run_job("distinct", 2, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 32'hFFFF_FFFF, 1'b0, 10, 2);
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++)
        check("distinct_y", ys(m*K+k), 64'(2*(m+1)*(k+1)));
    release_job("distinct", 0, 40'd32);

    // x=-3, w=5, len=2
    run_job("neg", 2, 64'hFFFD_FFFD_FFFD_FFFD, 64'h0005_0005_0005_0005, 32'hFFFF_FFFF, 1'b0, 10, 2);
    check_all("neg_y", 40'hFF_FFFF_FFE2);
    check_all_u("neg_yu", 32'h0009_FFE2);
    release_job("neg", 0, 40'hFF_FFFF_FFE2);

    // all-ones operands, len=1
    run_job("max1", 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 9, 1);
    check_all("max1_y", 40'd1);
    check_all_u("max1_yu", 32'hFFFE_0001);
    release_job("max1", 0, 40'd1);

    // all-ones operands, len=2: unsigned 32-bit accumulator wraps
    run_job("max2", 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10, 2);
    check_all("max2_y", 40'd2);
    check_all_u("max2_yu", 32'hFFFC_0002);
    release_job("max2", 0, 40'd2);

    // reset in the middle of a len=8 job
    start = 1'b1; len = LW'(8); x_data = 64'h0003_0003_0003_0003; w_data = 64'h0003_0003_0003_0003;
    step();
    start = 1'b0; in_valid = 1'b1;
    repeat (3) step();
    check("abort_in_ready", bus_s.in_ready, 1);
    check("abort_busy", bus_s.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_y", |bus_s.y_out, 0);
    check("abort_out_valid", bus_s.out_valid, 0);
    check("abort_in_ready_rst", bus_s.in_ready, 0);
    check("abort_busy_rst", bus_s.busy, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    run_job("recover", 1, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 32'hFFFF_FFFF, 1'b0, 9, 1);
    check_all("recover_y", 40'd1);
    release_job("recover", 0, 40'd1);

    // empty job
    run_job("len0", 0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 32'hFFFF_FFFF, 1'b0, 8, 0);
    check_all("len0_y", 40'd0);
    check_all_u("len0_yu", 32'd0);
    release_job("len0", 0, 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
